// File: rtl/prefetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg -- shared definitions for the instruction prefetch unit.
//   fetch_state_t : fetch FSM states (IDLE / WAIT / DROP)
//   INSTR_W       : instruction word width
//   PC_STEP       : byte distance between sequential instructions
// -----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        WAIT = 2'd1,  // request outstanding, returned data will be queued
        DROP = 2'd2   // request outstanding, returned data will be discarded
    } fetch_state_t;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

endpackage : mc_pkg

// File: rtl/prefetch_unit_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces of the prefetch unit.
//   fetch_mem_if : instruction memory request/acknowledge bus
//       master (prefetch unit): drives mem_req, mem_addr; receives mem_ack, mem_rdata
//       slave  (memory)       : the mirror image
//   instr_if     : instruction stream towards the decoder (valid/ready)
//       master (prefetch unit): drives ir_valid, ir_data, ir_pc; receives ir_ready
//       slave  (consumer)     : the mirror image
// -----------------------------------------------------------------------------
interface fetch_mem_if #(
    parameter int unsigned XLEN = 32
) ();
    import mc_pkg::*;

    logic               mem_req;
    logic [XLEN-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface : fetch_mem_if

interface instr_if #(
    parameter int unsigned XLEN = 32
) ();
    import mc_pkg::*;

    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir_data;
    logic [XLEN-1:0]    ir_pc;

    modport master (output ir_valid, ir_data, ir_pc, input  ir_ready);
    modport slave  (input  ir_valid, ir_data, ir_pc, output ir_ready);
endinterface : instr_if

// File: rtl/prefetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo -- small synchronous FIFO holding fetched {pc, instruction} pairs.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : enqueue wdata (ignored when full without a same-cycle pop)
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all entries; has priority over push and pop
//   count        : number of valid entries (0..DEPTH)
//   head         : oldest entry, read combinationally from registered storage
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, empty, wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A write into a full queue is accepted only when the head leaves in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: the storage is reset as well -- it is only DEPTH entries and the head must read as zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en && !flush) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule : fetch_fifo

// File: rtl/prefetch_unit.sv
// -----------------------------------------------------------------------------
// prefetch_unit -- sequential instruction prefetcher with a small queue.
//   clk, reset_n : clock, asynchronous active-low reset
//   mem          : fetch_mem_if.master -- one outstanding request at a time
//   redirect     : branch/jump; flushes the queue and restarts at redirect_pc
//   redirect_pc  : new fetch PC (low two bits forced to zero)
//   stall        : inhibits new requests; an outstanding request still completes
//   ir           : instr_if.master -- head of the instruction queue
//   count        : entries currently queued
// Parameters: XLEN (PC width), DEPTH (queue entries, power of two),
// RESET_PC (first fetch address after reset).
// -----------------------------------------------------------------------------
module prefetch_unit
    import mc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    fetch_mem_if.master                mem,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       stall,
    instr_if.master                    ir,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic [XLEN-1:0] next_seq_addr;
    logic            ir_valid;
    logic            push, pop;
    logic [CW:0]     fill_after_push;
    logic            room_to_continue;
    logic [XLEN+INSTR_W-1:0] head;

    assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);
    assign next_seq_addr       = mem_addr_q + XLEN'(PC_STEP);

    assign ir_valid = (count != '0);
    // redirect wins over both queue operations.
    assign pop  = ir_valid && ir.ir_ready && !redirect;
    assign push = (state_q == WAIT) && mem.mem_ack && !redirect;

    // Occupancy once this ack's entry lands; one extra bit keeps count+1 from wrapping.
    assign fill_after_push  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    assign room_to_continue = (fill_after_push < (CW+1)'(DEPTH)) && !stall;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                // An ack arriving here belongs to no request and is ignored.
                if (redirect) begin
                    fetch_pc_d = redirect_pc_aligned;
                end else if ((count < CW'(DEPTH)) && !stall) begin
                    state_d    = WAIT;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_aligned;
                    state_d    = mem.mem_ack ? IDLE : DROP;
                end else if (mem.mem_ack) begin
                    fetch_pc_d = next_seq_addr;
                    // Chain straight into the next sequential fetch when the queue
                    // still has room, so a streaming consumer sees no bubbles.
                    if (room_to_continue) begin
                        mem_addr_d = next_seq_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                // The stale request must finish on the bus at its original address.
                if (redirect) begin
                    fetch_pc_d = redirect_pc_aligned;
                end
                if (mem.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wdata   ({mem_addr_q, mem.mem_rdata}),
        .count   (count),
        .head    (head)
    );

    assign mem.mem_req  = (state_q != IDLE);
    assign mem.mem_addr = mem_addr_q;
    assign ir.ir_valid  = ir_valid;
    assign ir.ir_data   = head[INSTR_W-1:0];
    assign ir.ir_pc     = head[INSTR_W +: XLEN];

endmodule : prefetch_unit

// File: tb/tb_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_prefetch_unit -- directed bench for prefetch_unit.
//   dut0 : XLEN=32, DEPTH=4, RESET_PC=0x100; memory acks either automatically
//          (same cycle as the request is seen) or under manual control.
//   dut1 : XLEN=16, DEPTH=4, RESET_PC=0xFFFC; always-ack memory, consumer always
//          ready; used for PC wrap-around.
// Memory data is {tag, low 16 address bits} so every word identifies its PC.
// -----------------------------------------------------------------------------
module tb_prefetch_unit;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        ir_ready0;
    logic        auto_en;
    logic        man_ack;
    logic [2:0]  count0;
    logic [2:0]  count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_mem_if #(.XLEN(32)) mif0 ();
    instr_if     #(.XLEN(32)) iif0 ();
    fetch_mem_if #(.XLEN(16)) mif1 ();
    instr_if     #(.XLEN(16)) iif1 ();

    // Memory models: combinational reply from the registered request.
    assign mif0.mem_ack   = auto_en ? mif0.mem_req : man_ack;
    assign mif0.mem_rdata = {16'hC0DE, mif0.mem_addr[15:0]};
    assign iif0.ir_ready  = ir_ready0;

    assign mif1.mem_ack   = mif1.mem_req;
    assign mif1.mem_rdata = {16'hBEEF, mif1.mem_addr};
    assign iif1.ir_ready  = 1'b1;

    prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem         (mif0.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .ir          (iif0.master),
        .count       (count0)
    );

    prefetch_unit #(
        .XLEN     (16),
        .DEPTH    (4),
        .RESET_PC (16'hFFFC)
    ) dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem         (mif1.master),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .stall       (1'b0),
        .ir          (iif1.master),
        .count       (count1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        ir_ready0   = 1'b1;
        auto_en     = 1'b1;
        man_ack     = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_mem_req",  mif0.mem_req,  0);
        check("rst_mem_addr", mif0.mem_addr, 64'h100);
        check("rst_count",    count0,        0);
        check("rst_ir_valid", iif0.ir_valid, 0);
        check("rst_ir_data",  iif0.ir_data,  0);
        check("rst_ir_pc",    iif0.ir_pc,    0);
        check("rst16_addr",   mif1.mem_addr, 64'hFFFC);

        // ---- streaming fetch, 1-cycle ack, consumer always ready ----
        reset_n = 1'b1;
        tick();
        check("s_first_req",  mif0.mem_req,  1);
        check("s_first_addr", mif0.mem_addr, 64'h100);
        tick();
        check("s_pc0",        iif0.ir_pc,    64'h100);
        check("s_cnt0",       count0,        1);
        check("s_addr1",      mif0.mem_addr, 64'h104);
        check("w16_addr2",    mif1.mem_addr, 64'h0000);
        check("w16_pc0",      iif1.ir_pc,    64'hFFFC);
        tick();
        check("s_pc1",        iif0.ir_pc,    64'h104);
        check("s_valid1",     iif0.ir_valid, 1);
        check("w16_pc1",      iif1.ir_pc,    64'h0000);
        check("w16_data1",    iif1.ir_data,  64'hBEEF0000);
        tick();
        check("s_pc2",        iif0.ir_pc,    64'h108);
        check("s_data2",      iif0.ir_data,  64'hC0DE0108);
        check("s_req2",       mif0.mem_req,  1);

        // ---- consumer blocked: queue fills, requests stop ----
        ir_ready0 = 1'b0;
        repeat (4) tick();
        check("f_count",      count0,        4);
        check("f_req",        mif0.mem_req,  0);
        check("f_head",       iif0.ir_pc,    64'h108);
        ir_ready0 = 1'b1;
        tick();
        ir_ready0 = 1'b0;
        check("f_pop_cnt",    count0,        3);
        check("f_pop_head",   iif0.ir_pc,    64'h10C);
        tick();
        check("f_refill_req", mif0.mem_req,  1);
        check("f_refill_adr", mif0.mem_addr, 64'h118);
        tick();
        check("f_full_cnt",   count0,        4);
        check("f_full_req",   mif0.mem_req,  0);

        // ---- redirect while WAIT, ack two cycles later ----
        auto_en   = 1'b0;
        ir_ready0 = 1'b1;
        tick();
        ir_ready0 = 1'b0;
        tick();
        check("r_wait_addr",  mif0.mem_addr, 64'h11C);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        check("r_flush_cnt",  count0,        0);
        check("r_flush_vld",  iif0.ir_valid, 0);
        check("r_drop_req",   mif0.mem_req,  1);
        check("r_drop_addr",  mif0.mem_addr, 64'h11C);
        tick();
        check("r_drop_addr2", mif0.mem_addr, 64'h11C);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check("r_dropped",    count0,        0);
        check("r_idle_req",   mif0.mem_req,  0);
        tick();
        check("r_new_req",    mif0.mem_req,  1);
        check("r_new_addr",   mif0.mem_addr, 64'h200);

        // ---- redirect together with ack and pop ----
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check("c_cnt",        count0,        1);
        check("c_head",       iif0.ir_pc,    64'h200);
        check("c_data",       iif0.ir_data,  64'hC0DE0200);
        ir_ready0   = 1'b1;
        man_ack     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        ir_ready0 = 1'b0;
        man_ack   = 1'b0;
        redirect  = 1'b0;
        check("c_cnt0",       count0,        0);
        check("c_valid0",     iif0.ir_valid, 0);
        check("c_idle",       mif0.mem_req,  0);
        tick();
        check("c_new_addr",   mif0.mem_addr, 64'h300);

        // ---- stall: outstanding request completes, no new request, no flush ----
        stall   = 1'b1;
        man_ack = 1'b1;
        tick();
        check("t_cnt",        count0,        1);
        check("t_req",        mif0.mem_req,  0);
        check("t_head",       iif0.ir_pc,    64'h300);
        tick();                      // ack while IDLE must be ignored
        man_ack = 1'b0;
        check("t_idle_ack",   count0,        1);
        check("t_hold_req",   mif0.mem_req,  0);
        stall = 1'b0;
        tick();
        check("t_resume_req", mif0.mem_req,  1);
        check("t_resume_adr", mif0.mem_addr, 64'h304);

        // ---- asynchronous reset in the middle of a request ----
        reset_n = 1'b0;
        #1;
        check("a_req",        mif0.mem_req,  0);
        check("a_addr",       mif0.mem_addr, 64'h100);
        check("a_cnt",        count0,        0);
        check("a_valid",      iif0.ir_valid, 0);
        check("a_data",       iif0.ir_data,  0);
        check("a_pc",         iif0.ir_pc,    0);
        auto_en   = 1'b1;
        ir_ready0 = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        check("a_post_req",   mif0.mem_req,  1);
        check("a_post_addr",  mif0.mem_addr, 64'h100);
        check("a16_post_addr", mif1.mem_addr, 64'hFFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prefetch_unit

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width (>=16).
REQ-002 Parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset (word-aligned).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mem_req  out  1  fetch request; held high until mem_ack.
REQ-007 mem_addr  out  XLEN  fetch address; stable while mem_req high.
REQ-008 mem_ack  in  1  one-cycle pulse; mem_rdata valid that cycle.
REQ-009 mem_rdata  in  32  fetched instruction word.
REQ-010 redirect  in  1  branch/jump: flush queue and restart at redirect_pc.
REQ-011 redirect_pc  in  XLEN  new fetch PC.
REQ-012 stall  in  1  inhibit new requests; outstanding request still completes.
REQ-013 ir_valid  out  1  queue head holds an instruction.
REQ-014 ir_ready  in  1  consumer accepts head when ir_valid high.
REQ-015 ir_data  out  32  head instruction word.
REQ-016 ir_pc  out  XLEN  head instruction PC.
REQ-017 count  out  $clog2(DEPTH+1)  entries currently queued.

Function
REQ-018 FSM states SHALL be IDLE (no request), WAIT (request outstanding, data kept), DROP (request outstanding, data discarded); mem_req = (state != IDLE).
REQ-019 IDLE->WAIT SHALL occur when count < DEPTH, stall=0, redirect=0; mem_addr <= fetch_pc on that edge.
REQ-020 At most one request SHALL be outstanding; mem_ack in IDLE SHALL be ignored.
REQ-021 On mem_ack in WAIT without redirect: push {mem_addr, mem_rdata}; fetch_pc <= mem_addr + 4 (mod 2^XLEN).
REQ-022 After a WAIT ack the FSM SHALL stay in WAIT with mem_addr <= mem_addr+4 if (count + 1 - pop) < DEPTH and stall=0, else go IDLE; back-to-back fetches thus have zero bubble cycles.
REQ-023 A pop SHALL occur when ir_valid && ir_ready; ir_valid = (count != 0); ir_data/ir_pc SHALL show the head entry combinationally from registered storage.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; the queue SHALL never overflow.
REQ-025 redirect SHALL have priority over push, pop and issue: next cycle count=0, ir_valid=0, fetch_pc=redirect_pc with bits [1:0] forced to 0.
REQ-026 redirect in WAIT without mem_ack SHALL go to DROP; redirect in WAIT with mem_ack SHALL discard the data and go IDLE.
REQ-027 In DROP, mem_addr SHALL remain unchanged; mem_ack SHALL be discarded and the FSM SHALL go IDLE; a further redirect in DROP SHALL only update fetch_pc.
REQ-028 stall SHALL NOT flush the queue nor drop an outstanding request.

Reset
REQ-029 reset_n low SHALL immediately force state=IDLE, mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, ir_valid=0, ir_data=0, ir_pc=0, read/write pointers=0.
REQ-030 Reset mid-request SHALL abandon the request; the first post-reset request SHALL use RESET_PC.

Structure
REQ-031 Shared package mc_pkg SHALL hold fetch_state_t (IDLE/WAIT/DROP), INSTR_W=32, PC_STEP=4.
REQ-032 Queue storage SHALL be a sub-module fetch_fifo (WIDTH, DEPTH parameters; push, pop, flush, count, head).

Verification
REQ-033 Reset with RESET_PC=0x100, 1-cycle ack, ir_ready=1 -> ir_pc sequence 0x100,0x104,0x108 with no bubbles after first.
REQ-034 ir_ready=0, DEPTH=4 -> exactly 4 pushes, count=4, mem_req=0; one pop -> one new request at next sequential PC.
REQ-035 redirect to 0x203 while WAIT, ack 2 cycles later -> acked data dropped, count=0, next request mem_addr=0x200.
REQ-036 redirect in same cycle as mem_ack and ir_ready -> nothing pushed or popped, ir_valid=0 next cycle, FSM IDLE.
REQ-037 XLEN=16, RESET_PC=0xFFFC -> second fetch address 0x0000.
REQ-038 reset_n asserted mid-WAIT -> mem_req low at once, all outputs at reset values; release -> fetch from RESET_PC.
